// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file writeback path: data width,
// register address width, the commit phase and the buffered request record.
package regfile_wb_ctrl_pkg;

  localparam int          XLEN       = 32;
  localparam int          REG_ADDR_W = 5;
  localparam logic [1:0]  PHASE_WB   = 2'd1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer. Besides the usual head/count view it exposes
// every entry, a valid mask and the read pointer so the controller can run
// its busy/forward compare across everything still in flight.
module wb_fifo
  import regfile_wb_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush,
  input  logic                 i_push,
  input  wb_req_t              i_push_req,
  input  logic                 i_pop,
  output wb_req_t              o_head,
  output logic [CNT_W-1:0]     o_count,
  output logic                 o_full,
  output wb_req_t [DEPTH-1:0]  o_entries,
  output logic [DEPTH-1:0]     o_valid,
  output logic [PTR_W-1:0]     o_rd_ptr
);

  wb_req_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    w_vidx;
  logic [DEPTH-1:0]    w_valid;

  // Storage, pointers and occupancy; flush empties the buffer and beats push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_req;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    w_valid = '0;
    w_vidx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_vidx = r_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        w_valid[w_vidx] = 1'b1;
      end
    end
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_entries = r_mem;
  assign o_valid   = w_valid;
  assign o_rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side initiator for the register file. Arbitrates load/ALU writeback
// requests (load first, it is the older instruction), buffers them in order
// and presents the head to the register file, which commits on the edge
// where state==PHASE_WB. Decode gets busy flags and the youngest pending
// value for two query registers.
//
// Handshake: a request is taken on a rising clk edge when valid and ready
// are both high in the cycle before it; ready depends only on registered
// occupancy (and ld_valid for the ALU port), never on state, so a pop in
// the same edge does not make room for a push.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            state,
  input  logic                  flush,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [XLEN-1:0]       fwd1_data,
  output logic [XLEN-1:0]       fwd2_data,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       writedata,
  output logic                  regwrite
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t             w_head;
  wb_req_t             w_push_req;
  wb_req_t [DEPTH-1:0] w_entries;
  logic [DEPTH-1:0]    w_valid;
  logic [PTR_W-1:0]    w_rd_ptr;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_ld_acc;
  logic                w_alu_acc;
  logic                w_push;
  logic                w_pop;
  logic [PTR_W-1:0]    w_fidx;

  assign ld_ready  = !w_full;
  assign alu_ready = !w_full && !ld_valid;
  assign w_ld_acc  = ld_valid && ld_ready;
  assign w_alu_acc = alu_valid && alu_ready;

  // x0 writes are acknowledged but dropped: they have no architectural effect.
  assign w_push_req = w_ld_acc ? wb_req_t'{rd: ld_rd, data: ld_data}
                               : wb_req_t'{rd: alu_rd, data: alu_data};
  assign w_push     = (w_ld_acc || w_alu_acc) && (w_push_req.rd != '0);
  assign w_pop      = (state == PHASE_WB) && (w_count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_push     (w_push),
    .i_push_req (w_push_req),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_entries  (w_entries),
    .o_valid    (w_valid),
    .o_rd_ptr   (w_rd_ptr)
  );

  // Head goes straight to the register file; idle outputs are forced to zero.
  assign regwrite  = (w_count != '0);
  assign rd        = regwrite ? w_head.rd   : '0;
  assign writedata = regwrite ? w_head.data : '0;

  // Walk oldest to youngest so the last match seen is the youngest pending value.
  always_comb begin
    busy1     = 1'b0;
    busy2     = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    w_fidx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fidx = w_rd_ptr + PTR_W'(k);
      if (w_valid[w_fidx] && (q_rs1 != '0) && (w_entries[w_fidx].rd == q_rs1)) begin
        busy1     = 1'b1;
        fwd1_data = w_entries[w_fidx].data;
      end
      if (w_valid[w_fidx] && (q_rs2 != '0) && (w_entries[w_fidx].rd == q_rs2)) begin
        busy2     = 1'b1;
        fwd2_data = w_entries[w_fidx].data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, single write, arbitration,
// youngest forwarding, full/wrap, x0, flush and reset mid-drain. Commits are
// checked against an in-order expected queue on every state==1 edge.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  state = 2'd0;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [31:0] alu_data = 32'd0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = 5'd0;
  logic [31:0] ld_data = 32'd0;
  logic        ld_ready;
  logic [4:0]  q_rs1 = 5'd0;
  logic [4:0]  q_rs2 = 5'd0;
  logic        busy1, busy2;
  logic [31:0] fwd1_data, fwd2_data;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic        regwrite;

  logic [36:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // clock
  always #5 clk = ~clk;

  regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .busy1     (busy1),
    .busy2     (busy2),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .rd        (rd),
    .writedata (writedata),
    .regwrite  (regwrite)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: present state s to the next rising edge, return 2ns after it
  task automatic clk_with(input logic [1:0] s);
    state = s;
    @(posedge clk);
    #2;
  endtask

  task automatic run_phases(input int n);
    repeat (n) clk_with(state + 2'd1);
  endtask

  // scoreboard: inputs are stable at the falling edge, so what is seen here
  // is exactly what the next rising edge commits
  always @(negedge clk) begin
    if (rst_n && state == 2'd1 && regwrite) begin
      if (exp_q.size() == 0)
        check_eq("commit_unexpected", 64'(regwrite), 64'd0);
      else
        check_eq("commit", 64'({rd, writedata}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mcount;
    int pushed;
    int guard;
    logic exp_rdy;
    logic do_pop;

    // ---- reset / idle
    q_rs1 = 5'd5;
    q_rs2 = 5'd7;
    for (int i = 0; i < 3; i++) begin
      clk_with(2'(i));
      check_eq("rst_regwrite", 64'(regwrite), 64'd0);
      check_eq("rst_busy1", 64'(busy1), 64'd0);
      check_eq("rst_busy2", 64'(busy2), 64'd0);
    end
    check_eq("rst_rd", 64'(rd), 64'd0);
    check_eq("rst_writedata", 64'(writedata), 64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_alu_ready", 64'(alu_ready), 64'd1);
    check_eq("rst_ld_ready", 64'(ld_ready), 64'd1);

    // ---- single write x5 = DEADBEEF accepted at state 3
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; #1;
    check_eq("single_ready", 64'(alu_ready), 64'd1);
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    clk_with(2'd3);
    alu_valid = 1'b0; #1;
    check_eq("single_rd", 64'(rd), 64'd5);
    check_eq("single_wdata", 64'(writedata), 64'hDEAD_BEEF);
    check_eq("single_regwrite", 64'(regwrite), 64'd1);
    check_eq("single_busy1", 64'(busy1), 64'd1);
    check_eq("single_fwd1", 64'(fwd1_data), 64'hDEAD_BEEF);
    clk_with(2'd0);
    check_eq("single_hold", 64'(regwrite), 64'd1);
    state = 2'd1; #1;
    check_eq("pop_cycle_busy", 64'(busy1), 64'd1);
    clk_with(2'd1);
    check_eq("single_done", 64'(regwrite), 64'd0);
    check_eq("single_busy_clr", 64'(busy1), 64'd0);
    check_eq("single_fwd_clr", 64'(fwd1_data), 64'd0);

    // ---- arbitration: load x7 beats ALU x8
    state = 2'd2;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h22; #1;
    check_eq("arb_ld_ready", 64'(ld_ready), 64'd1);
    check_eq("arb_alu_ready", 64'(alu_ready), 64'd0);
    exp_q.push_back({5'd7, 32'h11});
    clk_with(2'd2);
    ld_valid = 1'b0; #1;
    check_eq("arb_alu_ready2", 64'(alu_ready), 64'd1);
    exp_q.push_back({5'd8, 32'h22});
    clk_with(2'd3);
    alu_valid = 1'b0; #1;
    check_eq("arb_head_x7", 64'(rd), 64'd7);
    run_phases(2);
    check_eq("arb_head_x8", 64'(rd), 64'd8);
    check_eq("arb_regwrite", 64'(regwrite), 64'd1);
    run_phases(4);
    check_eq("arb_drained", 64'(regwrite), 64'd0);

    // ---- youngest forward: x3 = 1, 2, 3
    q_rs1 = 5'd3;
    q_rs2 = 5'd9;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'(i);
      exp_q.push_back({5'd3, 32'(i)});
      clk_with(2'd2);
    end
    alu_valid = 1'b0; #1;
    check_eq("young_busy1", 64'(busy1), 64'd1);
    check_eq("young_fwd1", 64'(fwd1_data), 64'd3);
    check_eq("young_busy2_other", 64'(busy2), 64'd0);
    check_eq("young_fwd2_other", 64'(fwd2_data), 64'd0);
    q_rs2 = 5'd3; #1;
    check_eq("young_busy2", 64'(busy2), 64'd1);
    check_eq("young_fwd2", 64'(fwd2_data), 64'd3);
    run_phases(3);
    check_eq("young_after1_fwd", 64'(fwd1_data), 64'd3);
    run_phases(8);
    check_eq("young_done_busy", 64'(busy1), 64'd0);
    check_eq("young_done_fwd", 64'(fwd1_data), 64'd0);

    // ---- full and wrap
    mcount = 0;
    for (int i = 0; i < DEPTH; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(12 + i); alu_data = 32'hA000 + 32'(i); #1;
      check_eq("fill_ready", 64'(alu_ready), 64'd1);
      exp_q.push_back({alu_rd, alu_data});
      clk_with(2'd2);
      mcount++;
    end
    alu_rd = 5'd16; alu_data = 32'hA0FF; #1;
    check_eq("full_alu_ready", 64'(alu_ready), 64'd0);
    check_eq("full_ld_ready", 64'(ld_ready), 64'd0);
    clk_with(2'd2);
    state = 2'd1; #1;
    check_eq("full_pop_no_ready", 64'(alu_ready), 64'd0);
    clk_with(2'd1);
    mcount--;
    pushed = 0;
    guard  = 0;
    while (pushed < 10 && guard < 200) begin
      state = state + 2'd1;
      alu_valid = 1'b1; alu_rd = 5'(16 + pushed); alu_data = 32'hB000 + 32'(pushed); #1;
      exp_rdy = (mcount < DEPTH);
      do_pop  = (state == 2'd1) && (mcount != 0);
      check_eq("wrap_ready", 64'(alu_ready), 64'(exp_rdy));
      if (exp_rdy) begin
        exp_q.push_back({alu_rd, alu_data});
        pushed++;
      end
      mcount = mcount + (exp_rdy ? 1 : 0) - (do_pop ? 1 : 0);
      @(posedge clk);
      #2;
      guard++;
    end
    check_eq("wrap_pushed", 64'(pushed), 64'd10);
    alu_valid = 1'b0;
    run_phases(4 * DEPTH + 4);
    check_eq("wrap_regwrite", 64'(regwrite), 64'd0);
    check_eq("wrap_drained", 64'(exp_q.size()), 64'd0);

    // ---- x0 write: accepted, never buffered
    q_rs1 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55; #1;
    check_eq("x0_ready", 64'(alu_ready), 64'd1);
    clk_with(2'd2);
    alu_valid = 1'b0; #1;
    check_eq("x0_regwrite", 64'(regwrite), 64'd0);
    check_eq("x0_busy", 64'(busy1), 64'd0);
    run_phases(4);
    check_eq("x0_regwrite_late", 64'(regwrite), 64'd0);

    // ---- flush with 3 entries at state 1: head commits, rest dropped
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'hC0 + 32'(i);
      exp_q.push_back({alu_rd, alu_data});
      clk_with(2'd2);
    end
    alu_valid = 1'b0;
    q_rs1 = 5'd21;
    flush = 1'b1;
    state = 2'd1; #1;
    check_eq("flush_ready", 64'(alu_ready), 64'd1);
    check_eq("flush_busy_before", 64'(busy1), 64'd1);
    clk_with(2'd1);
    flush = 1'b0;
    exp_q.delete();
    #1;
    check_eq("flush_regwrite", 64'(regwrite), 64'd0);
    check_eq("flush_busy_after", 64'(busy1), 64'd0);
    check_eq("flush_fwd_after", 64'(fwd1_data), 64'd0);

    // ---- reset mid-drain
    q_rs1 = 5'd25;
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(25 + i); alu_data = 32'hD0 + 32'(i);
      exp_q.push_back({alu_rd, alu_data});
      clk_with(2'd2);
    end
    alu_valid = 1'b0;
    state = 2'd3; #1;
    check_eq("mid_regwrite", 64'(regwrite), 64'd1);
    rst_n = 1'b0; #1;
    check_eq("mid_rst_regwrite", 64'(regwrite), 64'd0);
    check_eq("mid_rst_rd", 64'(rd), 64'd0);
    check_eq("mid_rst_busy", 64'(busy1), 64'd0);
    exp_q.delete();
    clk_with(2'd0);
    rst_n = 1'b1; #1;
    check_eq("post_rst_ready", 64'(alu_ready), 64'd1);
    run_phases(4);
    check_eq("post_rst_regwrite", 64'(regwrite), 64'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
